// File: rtl/mem_access_unit.sv
// RV32I load/store initiator for a word-wide data RAM with a combinational read port.
// Sub-word stores use read-modify-write; misaligned or illegal requests never reach the RAM.
module mem_access_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [2:0]            i_req_funct3,
    input  logic [DATA_WIDTH-1:0] i_req_addr,
    input  logic [DATA_WIDTH-1:0] i_req_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic [DATA_WIDTH-1:0] o_mem_a,
    output logic [DATA_WIDTH-1:0] o_mem_wd,
    output logic                  o_mem_we,
    input  logic [DATA_WIDTH-1:0] i_mem_rd
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_RESP} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_we;
    logic [2:0]              r_funct3;
    logic [DATA_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_merge;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;

    logic                    w_accept;
    logic                    w_req_err;
    logic                    w_is_sw;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [DATA_WIDTH-1:0]   w_load;
    logic [DATA_WIDTH-1:0]   w_merge;
    logic [3:0]              w_lane_hit;
    logic [DATA_WIDTH-1:0]   w_word_addr;

    assign w_accept    = i_req_valid && (r_state == S_IDLE);
    assign w_is_sw     = r_we && (r_funct3 == F3_W);
    assign w_word_addr = {r_addr[DATA_WIDTH-1:2], 2'b00};

    // Alignment and funct3 legality of the incoming request
    always_comb begin
        w_req_err = 1'b1;
        case (i_req_funct3)
            F3_B:    w_req_err = 1'b0;
            F3_H:    w_req_err = i_req_addr[0];
            F3_W:    w_req_err = |i_req_addr[1:0];
            F3_BU:   w_req_err = i_req_we;
            F3_HU:   w_req_err = i_req_we | i_req_addr[0];
            default: w_req_err = 1'b1;
        endcase
    end

    assign w_byte = i_mem_rd[8*r_addr[1:0] +: 8];
    assign w_half = i_mem_rd[16*r_addr[1] +: 16];

    always_comb begin
        w_load = i_mem_rd;
        case (r_funct3)
            F3_B:    w_load = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
            F3_H:    w_load = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
            F3_BU:   w_load = {{(DATA_WIDTH-8){1'b0}}, w_byte};
            F3_HU:   w_load = {{(DATA_WIDTH-16){1'b0}}, w_half};
            default: w_load = i_mem_rd;
        endcase
    end

    // Per-byte merge: SB drives wdata[7:0] into its lane, SH drives wdata[15:0] into its half
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign w_lane_hit[gi] = (r_funct3 == F3_B) ? (r_addr[1:0] == LANE)
                                                       : (r_addr[1] == LANE[1]);
            assign w_merge[8*gi +: 8] = !w_lane_hit[gi]      ? i_mem_rd[8*gi +: 8] :
                                        (r_funct3 == F3_B)   ? r_wdata[7:0]
                                                             : r_wdata[8*(gi%2) +: 8];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_next = w_req_err ? S_RESP : S_ACCESS;
            S_ACCESS: w_state_next = (r_we && !w_is_sw) ? S_WRITE : S_RESP;
            S_WRITE:  w_state_next = S_RESP;
            S_RESP:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Write enable is decoded from state so an asynchronous reset kills it immediately
    always_comb begin
        o_req_ready = (r_state == S_IDLE);
        o_rsp_valid = (r_state == S_RESP);
        o_mem_we    = ((r_state == S_ACCESS) && w_is_sw) || (r_state == S_WRITE);
        o_mem_a     = '0;
        o_mem_wd    = '0;
        if ((r_state == S_ACCESS) || (r_state == S_WRITE)) o_mem_a = w_word_addr;
        if ((r_state == S_ACCESS) && w_is_sw)              o_mem_wd = r_wdata;
        if (r_state == S_WRITE)                            o_mem_wd = r_merge;
    end

    assign o_rsp_rdata = r_rdata;
    assign o_rsp_err   = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_merge  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_we     <= i_req_we;
                        r_funct3 <= i_req_funct3;
                        r_addr   <= i_req_addr;
                        r_wdata  <= i_req_wdata;
                        if (w_req_err) begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!r_we) begin
                        r_rdata <= w_load;
                        r_err   <= 1'b0;
                    end else if (w_is_sw) begin
                        r_rdata <= '0;
                        r_err   <= 1'b0;
                    end else begin
                        r_merge <= w_merge;
                    end
                end
                S_WRITE: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
